// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM states, the XZR register number and the bundled stage-control outputs.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2,
        HALT     = 2'd3
    } hz_state_t;

    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_ex_hold;
        logic id_ex_flush;
        logic ex_mem_hold;
        logic ex_mem_flush;
        logic mem_wb_flush;
        logic pc_redirect;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NONE = '{
        pc_hold: 1'b0, if_id_hold: 1'b0, if_id_flush: 1'b0,
        id_ex_hold: 1'b0, id_ex_flush: 1'b0, ex_mem_hold: 1'b0,
        ex_mem_flush: 1'b0, mem_wb_flush: 1'b0, pc_redirect: 1'b0
    };

    // Freeze PC..EX/MEM and drain a bubble into MEM/WB while memory is busy.
    localparam stage_ctrl_t CTRL_STALL = '{
        pc_hold: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0,
        id_ex_hold: 1'b1, id_ex_flush: 1'b0, ex_mem_hold: 1'b1,
        ex_mem_flush: 1'b0, mem_wb_flush: 1'b1, pc_redirect: 1'b0
    };

    localparam stage_ctrl_t CTRL_BRANCH = '{
        pc_hold: 1'b0, if_id_hold: 1'b0, if_id_flush: 1'b1,
        id_ex_hold: 1'b0, id_ex_flush: 1'b1, ex_mem_hold: 1'b0,
        ex_mem_flush: 1'b1, mem_wb_flush: 1'b0, pc_redirect: 1'b1
    };

    localparam stage_ctrl_t CTRL_LOAD_USE = '{
        pc_hold: 1'b1, if_id_hold: 1'b1, if_id_flush: 1'b0,
        id_ex_hold: 1'b0, id_ex_flush: 1'b1, ex_mem_hold: 1'b0,
        ex_mem_flush: 1'b0, mem_wb_flush: 1'b0, pc_redirect: 1'b0
    };

    localparam stage_ctrl_t CTRL_IF_FLUSH = '{
        pc_hold: 1'b0, if_id_hold: 1'b0, if_id_flush: 1'b1,
        id_ex_hold: 1'b0, id_ex_flush: 1'b0, ex_mem_hold: 1'b0,
        ex_mem_flush: 1'b0, mem_wb_flush: 1'b0, pc_redirect: 1'b0
    };

    // A load in EX feeding a source of the ID instruction; XZR never conflicts.
    function automatic logic load_use_hazard(
        input logic [4:0] rn,
        input logic [4:0] rm,
        input logic       uses_rm,
        input logic [4:0] rd,
        input logic       mem_read,
        input logic       reg_write
    );
        return mem_read && reg_write && (rd != XZR) &&
               ((rd == rn) || (uses_rm && (rd == rm)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with synchronous reset/clear, parallel load,
// increment (sticks at all-ones) and decrement (sticks at zero).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_C = {W{1'b1}};
    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONE_C = W'(1);

    logic [W-1:0] count_r;

    // Count register: clear beats load beats inc beats dec.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= ZERO_C;
        end else if (load) begin
            count_r <= load_val;
        end else if (inc) begin
            if (count_r != MAX_C) begin
                count_r <= count_r + ONE_C;
            end else begin
                count_r <= count_r;
            end
        end else if (dec) begin
            if (count_r != ZERO_C) begin
                count_r <= count_r - ONE_C;
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add stall/flush/load-use event counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_Rn,
    input  logic [4:0]       id_Rm,
    input  logic             id_uses_Rm,
    input  logic [4:0]       ex_Rd,
    input  logic             ex_MemRead,
    input  logic             ex_RegWrite,
    input  logic             mem_BranchTaken,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ready,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             pc_redirect,
    output logic             mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] load_use_events
`endif
);

    localparam logic [CNT_W-1:0] ZERO_C       = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] FLUSH_INIT_C = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit               MULTI_FLUSH_C = (FLUSH_CYCLES > 1);

    hz_state_t        state_r;
    hz_state_t        next_state_s;
    logic             ret_flush_r;
    logic             next_ret_s;
    logic             mem_timeout_r;
    stage_ctrl_t      ctrl_s;
    stage_ctrl_t      ctrl_out_s;
    logic             mem_stall_s;
    logic             load_use_s;
    logic             wait_load_s;
    logic             wait_inc_s;
    logic             flush_load_s;
    logic             flush_dec_s;
    logic             timeout_set_s;
    logic [CNT_W-1:0] wait_cnt_s;
    logic [CNT_W-1:0] flush_cnt_s;

    assign mem_stall_s = (mem_MemRead | mem_MemWrite) & ~dmem_ready;
    assign load_use_s  = load_use_hazard(id_Rn, id_Rm, id_uses_Rm, ex_Rd,
                                         ex_MemRead, ex_RegWrite);

    // Next-state and stage-control decode; hold always beats flush.
    always_comb begin
        ctrl_s        = CTRL_NONE;
        next_state_s  = state_r;
        next_ret_s    = ret_flush_r;
        wait_load_s   = 1'b0;
        wait_inc_s    = 1'b0;
        flush_load_s  = 1'b0;
        flush_dec_s   = 1'b0;
        timeout_set_s = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_stall_s) begin
                    ctrl_s       = CTRL_STALL;
                    wait_load_s  = 1'b1;
                    next_ret_s   = 1'b0;
                    next_state_s = MEM_WAIT;
                end else if (mem_BranchTaken) begin
                    ctrl_s = CTRL_BRANCH;
                    if (MULTI_FLUSH_C) begin
                        flush_load_s = 1'b1;
                        next_state_s = BR_FLUSH;
                    end else begin
                        next_state_s = RUN;
                    end
                end else if (load_use_s) begin
                    ctrl_s = CTRL_LOAD_USE;
                end else begin
                    ctrl_s = CTRL_NONE;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    next_state_s = ret_flush_r ? BR_FLUSH : RUN;
                end else if (wait_cnt_s == TIMEOUT_C) begin
                    ctrl_s        = CTRL_STALL;
                    timeout_set_s = 1'b1;
                    next_state_s  = HALT;
                end else begin
                    ctrl_s     = CTRL_STALL;
                    wait_inc_s = 1'b1;
                end
            end
            BR_FLUSH: begin
                // A memory stall freezes the flush count until release.
                if (mem_stall_s) begin
                    ctrl_s       = CTRL_STALL;
                    wait_load_s  = 1'b1;
                    next_ret_s   = 1'b1;
                    next_state_s = MEM_WAIT;
                end else begin
                    ctrl_s = CTRL_IF_FLUSH;
                    if (flush_cnt_s <= ONE_C) begin
                        next_state_s = RUN;
                    end else begin
                        flush_dec_s = 1'b1;
                    end
                end
            end
            HALT: begin
                ctrl_s       = CTRL_STALL;
                next_state_s = HALT;
            end
            default: begin
                ctrl_s       = CTRL_STALL;
                next_state_s = RUN;
            end
        endcase
    end

    // FSM state, flush-resume flag and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= RUN;
            ret_flush_r   <= 1'b0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            ret_flush_r   <= next_ret_s;
            mem_timeout_r <= mem_timeout_r | timeout_set_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (wait_load_s),
        .load_val (ONE_C),
        .inc      (wait_inc_s),
        .dec      (1'b0),
        .count    (wait_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (flush_load_s),
        .load_val (FLUSH_INIT_C),
        .inc      (1'b0),
        .dec      (flush_dec_s),
        .count    (flush_cnt_s)
    );

    assign ctrl_out_s   = reset ? CTRL_NONE : ctrl_s;
    assign pc_hold      = ctrl_out_s.pc_hold;
    assign if_id_hold   = ctrl_out_s.if_id_hold;
    assign if_id_flush  = ctrl_out_s.if_id_flush;
    assign id_ex_hold   = ctrl_out_s.id_ex_hold;
    assign id_ex_flush  = ctrl_out_s.id_ex_flush;
    assign ex_mem_hold  = ctrl_out_s.ex_mem_hold;
    assign ex_mem_flush = ctrl_out_s.ex_mem_flush;
    assign mem_wb_flush = ctrl_out_s.mem_wb_flush;
    assign pc_redirect  = ctrl_out_s.pc_redirect;
    assign mem_timeout  = mem_timeout_r;

`ifdef HAZARD_PERF_CNT_EN
    // pc_redirect marks a branch acceptance; pc_hold with id_ex_flush only occurs on a load-use stall.
    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val (ZERO_C),
        .inc      (ctrl_out_s.pc_hold),
        .dec      (1'b0),
        .count    (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_events (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val (ZERO_C),
        .inc      (ctrl_out_s.pc_redirect),
        .dec      (1'b0),
        .count    (flush_events)
    );

    sat_counter #(.W(CNT_W)) u_load_use_events (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .load     (1'b0),
        .load_val (ZERO_C),
        .inc      (ctrl_out_s.pc_hold & ctrl_out_s.id_ex_flush),
        .dec      (1'b0),
        .count    (load_use_events)
    );
`endif

endmodule
